// File: rtl/udma_smi_sched_if.sv
// SMI controller handshake bundle: the scheduler drives one transaction at a time
// and the controller answers with busy and read data.
interface udma_smi_sched_if;
    logic        smi_start_o;
    logic        smi_busy_i;
    logic        smi_rw_o;
    logic [4:0]  smi_phy_addr_o;
    logic [4:0]  smi_reg_addr_o;
    logic [15:0] smi_wr_data_o;
    logic [15:0] smi_rd_data_i;

    modport master (
        output smi_start_o,
        output smi_rw_o,
        output smi_phy_addr_o,
        output smi_reg_addr_o,
        output smi_wr_data_o,
        input  smi_busy_i,
        input  smi_rd_data_i
    );

    modport slave (
        input  smi_start_o,
        input  smi_rw_o,
        input  smi_phy_addr_o,
        input  smi_reg_addr_o,
        input  smi_wr_data_o,
        output smi_busy_i,
        output smi_rd_data_i
    );
endinterface

// File: rtl/udma_smi_sched.sv
// Shares one SMI (MDIO) controller between host transactions and a periodic
// auto-poll read, with round-robin arbitration when both are waiting.
module udma_smi_sched #(
    parameter int POLL_CNT_W = 24
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,

    input  logic                  host_req_i,
    input  logic                  host_rw_i,
    input  logic [4:0]            host_phy_addr_i,
    input  logic [4:0]            host_reg_addr_i,
    input  logic [15:0]           host_wr_data_i,
    output logic                  host_ack_o,
    output logic                  host_done_o,
    output logic [15:0]           host_rd_data_o,

    input  logic                  poll_en_i,
    input  logic [4:0]            poll_phy_addr_i,
    input  logic [4:0]            poll_reg_addr_i,
    input  logic [POLL_CNT_W-1:0] poll_interval_i,
    output logic                  poll_valid_o,
    output logic                  poll_change_o,
    output logic [15:0]           poll_data_o,

    udma_smi_sched_if.master      smi
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic [POLL_CNT_W-1:0] CNT_ONE = POLL_CNT_W'(1);

    state_t                r_state;
    state_t                w_next;

    logic                  r_last_poll;
    logic                  r_cur_host;
    logic                  r_poll_pend;
    logic [POLL_CNT_W-1:0] r_cnt;
    logic                  r_en_d;
    logic                  r_first;

    logic                  r_rw;
    logic [4:0]            r_phy;
    logic [4:0]            r_reg;
    logic [15:0]           r_wdata;

    logic                  r_host_done;
    logic [15:0]           r_host_rd;
    logic                  r_poll_valid;
    logic                  r_poll_change;
    logic [15:0]           r_poll_data;

    logic                  w_any_pend;
    logic                  w_grant_host;
    logic                  w_launch;
    logic                  w_finish;
    logic                  w_expire;
    logic [POLL_CNT_W-1:0] w_reload;
    logic                  w_smi_start;
    logic                  w_host_ack;

    // Host wins unless a poll is also waiting and the host was served last.
    assign w_any_pend   = host_req_i | r_poll_pend;
    assign w_grant_host = host_req_i & (~r_poll_pend | r_last_poll);
    assign w_launch     = (r_state == IDLE) & w_any_pend;
    assign w_finish     = (r_state == WAIT_DONE) & ~smi.smi_busy_i;

    assign w_reload = (poll_interval_i == '0) ? '0 : (poll_interval_i - CNT_ONE);
    assign w_expire = poll_en_i & (r_cnt == '0);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (w_any_pend)       w_next = START;
            START:                           w_next = WAIT_BUSY;
            WAIT_BUSY: if (smi.smi_busy_i)   w_next = WAIT_DONE;
            WAIT_DONE: if (!smi.smi_busy_i)  w_next = IDLE;
            default:                         w_next = IDLE;
        endcase
    end

    always_comb begin
        w_smi_start = 1'b0;
        w_host_ack  = 1'b0;
        if (r_state == START) begin
            w_smi_start = 1'b1;
            w_host_ack  = r_cur_host;
        end
    end

    // Transaction fields are frozen at launch and ignored until the next IDLE.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rw        <= 1'b0;
            r_phy       <= '0;
            r_reg       <= '0;
            r_wdata     <= '0;
            r_cur_host  <= 1'b0;
            r_last_poll <= 1'b1;
        end else if (w_launch) begin
            r_cur_host  <= w_grant_host;
            r_last_poll <= ~w_grant_host;
            if (w_grant_host) begin
                r_rw    <= host_rw_i;
                r_phy   <= host_phy_addr_i;
                r_reg   <= host_reg_addr_i;
                r_wdata <= host_wr_data_i;
            end else begin
                r_rw    <= 1'b1;
                r_phy   <= poll_phy_addr_i;
                r_reg   <= poll_reg_addr_i;
                r_wdata <= '0;
            end
        end
    end

    // A fresh expiry outranks the grant-clear, so an interval of 0 keeps a poll
    // permanently pending; an expiry while already pending is simply absorbed.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt       <= '0;
            r_poll_pend <= 1'b0;
        end else if (!poll_en_i) begin
            r_cnt       <= w_reload;
            r_poll_pend <= 1'b0;
        end else begin
            if (r_cnt == '0) begin
                r_cnt <= w_reload;
            end else begin
                r_cnt <= r_cnt - CNT_ONE;
            end
            if (w_expire) begin
                r_poll_pend <= 1'b1;
            end else if (w_launch && !w_grant_host) begin
                r_poll_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_en_d  <= 1'b0;
            r_first <= 1'b0;
        end else begin
            r_en_d <= poll_en_i;
            if (poll_en_i && !r_en_d) begin
                r_first <= 1'b1;
            end else if (w_finish && !r_cur_host) begin
                r_first <= 1'b0;
            end
        end
    end

    // Completion side: results and pulses are published on the WAIT_DONE->IDLE edge.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_host_done   <= 1'b0;
            r_host_rd     <= '0;
            r_poll_valid  <= 1'b0;
            r_poll_change <= 1'b0;
            r_poll_data   <= '0;
        end else begin
            r_host_done   <= w_finish & r_cur_host;
            r_poll_valid  <= w_finish & ~r_cur_host;
            r_poll_change <= w_finish & ~r_cur_host &
                             ((smi.smi_rd_data_i != r_poll_data) | r_first);
            if (w_finish && r_cur_host && r_rw) begin
                r_host_rd <= smi.smi_rd_data_i;
            end
            if (w_finish && !r_cur_host) begin
                r_poll_data <= smi.smi_rd_data_i;
            end
        end
    end

    assign host_ack_o         = w_host_ack;
    assign host_done_o        = r_host_done;
    assign host_rd_data_o     = r_host_rd;
    assign poll_valid_o       = r_poll_valid;
    assign poll_change_o      = r_poll_change;
    assign poll_data_o        = r_poll_data;

    assign smi.smi_start_o    = w_smi_start;
    assign smi.smi_rw_o       = r_rw;
    assign smi.smi_phy_addr_o = r_phy;
    assign smi.smi_reg_addr_o = r_reg;
    assign smi.smi_wr_data_o  = r_wdata;
endmodule
